instr_mem_fetch: RTL and testbench

//  Parametrised, writable instruction memory with a registered valid/ready fetch port.

---
 rtl/instr_mem_fetch.sv | 80 ++++++++
 tb/tb_instr_mem_fetch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: writable instruction memory with a registered valid/ready fetch port and halt parking
module instr_mem_fetch #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                DEPTH     = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_en,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_clr,
  output logic              prog_err,
  input  logic              resume,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic              rsp_halt,
  output logic              rsp_oob,
  output logic              halted
);
  typedef enum logic [1:0] {RUN, PROG, HALTED} state_e;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  state_e            state_q, state_d;
  logic [DEPTH-1:0]  wr_q, wr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rsp_instr_q, rsp_instr_d, rd_word;
  logic              rsp_valid_q, rsp_valid_d, rsp_halt_q, rsp_halt_d, rsp_oob_q, rsp_oob_d;
  logic              prog_err_q, prog_err_d, req_in, prog_in, accept, prog_wr;
  assign req_in    = {1'b0, req_addr} < DEPTH_L;
  assign prog_in   = {1'b0, prog_addr} < DEPTH_L;
  assign prog_wr   = prog_en && prog_in;
  assign req_ready = (state_q == RUN) && !prog_en && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;
  // Reads never coincide with a write: accepting a request requires prog_en low
  assign rd_word   = (!req_in || !wr_q[req_addr]) ? HALT_WORD : mem_q[req_addr];
  always_comb begin
    state_d = (state_q == RUN)  ? (prog_en ? PROG : (rsp_valid_q && rsp_ready && rsp_halt_q) ? HALTED : RUN) :
              (state_q == PROG) ? (prog_en ? PROG : RUN) :
                                  (prog_en ? PROG : resume ? RUN : HALTED);
    wr_d        = prog_clr ? '0 : prog_wr ? (wr_q | (DEPTH'(1) << prog_addr)) : wr_q;
    rsp_valid_d = accept | (rsp_valid_q & ~rsp_ready);
    rsp_instr_d = accept ? rd_word : rsp_instr_q;
    rsp_halt_d  = accept ? (rd_word == HALT_WORD) : rsp_halt_q;
    rsp_oob_d   = accept ? !req_in : rsp_oob_q;
    prog_err_d  = prog_err_q | (prog_en & ~prog_in);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wr_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= HALT_WORD;
      rsp_halt_q  <= 1'b0;
      rsp_oob_q   <= 1'b0;
      prog_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_halt_q  <= rsp_halt_d;
      rsp_oob_q   <= rsp_oob_d;
      prog_err_q  <= prog_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (prog_wr) mem_q[prog_addr] <= prog_data;
  end
  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_halt  = rsp_halt_q;
  assign rsp_oob   = rsp_oob_q;
  assign prog_err  = prog_err_q;
  assign halted    = (state_q == HALTED);
endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb_instr_mem_fetch: directed self-checking bench for instr_mem_fetch (DEPTH=24)
module tb_instr_mem_fetch;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        prog_en = 1'b0, prog_clr = 1'b0, resume = 1'b0;
  logic [4:0]  prog_addr = '0, req_addr = '0;
  logic [31:0] prog_data = '0;
  logic        req_valid = 1'b0, rsp_ready = 1'b0;
  logic        prog_err, req_ready, rsp_valid, rsp_halt, rsp_oob, halted;
  logic [31:0] rsp_instr;
  int          checks = 0, failures = 0;

  instr_mem_fetch #(.DATA_W(32), .ADDR_W(5), .DEPTH(24), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_clr(prog_clr), .prog_err(prog_err), .resume(resume), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_halt(rsp_halt), .rsp_oob(rsp_oob), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [4:0] a, input logic [31:0] d);
    prog_en = 1'b1; prog_addr = a; prog_data = d;
    tick;
  endtask

  // Single fetch with an always-ready consumer; a halt response parks the block, so resume it
  task automatic fetch(input string tag, input logic [4:0] a, input logic [31:0] exp, input logic oob);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = a;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'd1);
    tick;
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_instr"}, rsp_instr, exp);
    check({tag, "_oob"}, 32'(rsp_oob), 32'(oob));
    tick;
    check({tag, "_drain"}, 32'(rsp_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'(exp == HW));
    if (exp == HW) begin
      resume = 1'b1;
      tick;
      resume = 1'b0;
    end
  endtask

  initial begin
    tick; tick;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_instr", rsp_instr, HW);
    check("rst_halt", 32'(rsp_halt), 32'd0);
    check("rst_oob", 32'(rsp_oob), 32'd0);
    check("rst_err", 32'(prog_err), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    tick;
    // Unprogrammed fetches: each halt handshake parks, resume returns to RUN
    for (int a = 0; a < 4; a++) begin
      req_valid = 1'b1; req_addr = 5'(a); rsp_ready = 1'b0;
      #1 check("t1_ready", 32'(req_ready), 32'd1);
      tick;
      req_valid = 1'b0;
      check("t1_valid", 32'(rsp_valid), 32'd1);
      check("t1_instr", rsp_instr, HW);
      check("t1_halt", 32'(rsp_halt), 32'd1);
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      check("t1_halted", 32'(halted), 32'd1);
      #1 check("t1_halt_ready", 32'(req_ready), 32'd0);
      resume = 1'b1;
      tick;
      resume = 1'b0;
      check("t5_resume", 32'(halted), 32'd0);
      #1 check("t5_resume_ready", 32'(req_ready), 32'd1);
    end
    prog(5'd0, 32'h0080_0293);
    prog(5'd1, 32'h00f0_0313);
    prog(5'd2, 32'h0062_a023);
    prog_en = 1'b0;
    #1 check("t2_prog_busy", 32'(req_ready), 32'd0);
    tick;
    check("t2_err", 32'(prog_err), 32'd0);
    // Streamed fetch with a 3-cycle stall on the second response
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 5'd0;
    tick;
    check("t2_r0_valid", 32'(rsp_valid), 32'd1);
    check("t2_r0", rsp_instr, 32'h0080_0293);
    check("t2_r0_halt", 32'(rsp_halt), 32'd0);
    req_addr = 5'd1;
    #1 check("t2_b2b_ready", 32'(req_ready), 32'd1);
    tick;
    check("t2_r1", rsp_instr, 32'h00f0_0313);
    rsp_ready = 1'b0; req_addr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_stall_ready", 32'(req_ready), 32'd0);
      tick;
      check("t3_stall_valid", 32'(rsp_valid), 32'd1);
      check("t3_stall_instr", rsp_instr, 32'h00f0_0313);
    end
    rsp_ready = 1'b1;
    #1 check("t3_release_ready", 32'(req_ready), 32'd1);
    tick;
    check("t3_r2", rsp_instr, 32'h0062_a023);
    req_valid = 1'b0;
    tick;
    check("t3_fall", 32'(rsp_valid), 32'd0);
    // Out-of-range fetch and programming
    fetch("t4_oob", 5'd30, HW, 1'b1);
    fetch("t4_inrange", 5'd2, 32'h0062_a023, 1'b0);
    req_valid = 1'b1; req_addr = 5'd29;
    tick;
    req_valid = 1'b0;
    check("t4_oob_halt", 32'(rsp_halt), 32'd1);
    tick;
    check("t4_parked", 32'(halted), 32'd1);
    prog_en = 1'b1; resume = 1'b1; prog_addr = 5'd30; prog_data = 32'h1234_5678;
    tick;
    prog_en = 1'b0; resume = 1'b0;
    check("t4_err", 32'(prog_err), 32'd1);
    check("t5_prog_not_halted", 32'(halted), 32'd0);
    #1 check("t5_in_prog", 32'(req_ready), 32'd0);
    tick;
    #1 check("t5_back_run", 32'(req_ready), 32'd1);
    // Clear, then clear colliding with a write: the written word stays unwritten
    prog_clr = 1'b1;
    tick;
    prog_clr = 1'b0;
    fetch("t5_clr1", 5'd1, HW, 1'b0);
    prog(5'd3, 32'h0000_abcd);
    prog_clr = 1'b1;
    prog(5'd2, 32'h5555_aaaa);
    prog_clr = 1'b0; prog_en = 1'b0;
    tick;
    fetch("t5_clrwin", 5'd2, HW, 1'b0);
    fetch("t5_cleared3", 5'd3, HW, 1'b0);
    prog(5'd3, 32'h0000_abcd);
    prog_en = 1'b0;
    tick;
    fetch("t5_w3", 5'd3, 32'h0000_abcd, 1'b0);
    check("t4_err_sticky", 32'(prog_err), 32'd1);
    // Async reset while a response is stalled
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 5'd3;
    tick;
    req_valid = 1'b0;
    check("t6_pending", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1 check("t6_async_valid", 32'(rsp_valid), 32'd0);
    check("t6_async_instr", rsp_instr, HW);
    check("t6_async_err", 32'(prog_err), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    check("t6_halted", 32'(halted), 32'd0);
    check("t6_err", 32'(prog_err), 32'd0);
    for (int a = 0; a < 4; a++) fetch("t6_wiped", 5'(a), HW, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
